alu_issue_stage: RTL and testbench

ID/EX issue stage that drives the execute-stage ALU. Each cycle it accepts one decoded instruction from ID: opcode, funct3, funct7 bit 5, operands, immediate and PC. It decodes these into the 4-bit ALU operation code and selects the `a`/`b` operands, then presents them registered to EX under a valid/ready handshake. The stage also supports stall, flush and an issued-operation counter.

---
 rtl/alu_issue_stage.sv | 214 +++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage
// Description : ID/EX issue stage. Decodes opcode/funct fields into a 4-bit
//               ALU operation, selects the a/b operands and presents them
//               registered to EX under a valid/ready handshake. Supports
//               flush and counts completed output handshakes.
//               Optional macro ALU_ISSUE_SKID_EN adds a one-entry skid
//               buffer so that in_ready does not depend on out_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_control,
    output logic            illegal,
    output logic [31:0]     issue_count
);

    // ALU operation codes
    localparam logic [3:0] c_ALU_AND  = 4'b0000;
    localparam logic [3:0] c_ALU_OR   = 4'b0001;
    localparam logic [3:0] c_ALU_ADD  = 4'b0010;
    localparam logic [3:0] c_ALU_SUB  = 4'b0110;
    localparam logic [3:0] c_ALU_SLT  = 4'b0111;
    localparam logic [3:0] c_ALU_XOR  = 4'b1000;
    localparam logic [3:0] c_ALU_SLL  = 4'b1001;
    localparam logic [3:0] c_ALU_SLTU = 4'b1010;
    localparam logic [3:0] c_ALU_SRL  = 4'b1011;
    localparam logic [3:0] c_ALU_SRA  = 4'b1100;
    localparam logic [3:0] c_ALU_ILL  = 4'b1111;

    // Major opcodes
    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;

    // Payload layout: {illegal, alu_control, alu_a, alu_b}
    localparam int             c_PW          = 2 * XLEN + 5;
    localparam logic [c_PW-1:0] c_RST_PAYLOAD = {1'b0, c_ALU_ADD, {(2 * XLEN){1'b0}}};

    // Arithmetic funct3 mapping shared by R-type and I-type; sub_ok is low
    // for I-type because ADDI has no subtract form.
    function automatic logic [3:0] f_arith(input logic [2:0] f3,
                                           input logic       f75,
                                           input logic       sub_ok);
        logic [3:0] code;
        case (f3)
            3'b000:  code = (sub_ok && f75) ? c_ALU_SUB : c_ALU_ADD;
            3'b001:  code = c_ALU_SLL;
            3'b010:  code = c_ALU_SLT;
            3'b011:  code = c_ALU_SLTU;
            3'b100:  code = c_ALU_XOR;
            3'b101:  code = f75 ? c_ALU_SRA : c_ALU_SRL;
            3'b110:  code = c_ALU_OR;
            default: code = c_ALU_AND;
        endcase
        return code;
    endfunction

    logic [3:0]      w_ctrl;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic            w_illegal;
    logic [c_PW-1:0] w_payload;
    logic            w_accept;
    logic            w_hs;

    logic            r_out_valid;
    logic [c_PW-1:0] r_out;
    logic [31:0]     r_count;

    // Decode the incoming instruction into operation and operand selection
    always_comb begin
        w_ctrl    = c_ALU_ADD;
        w_a       = rs1_val;
        w_b       = rs2_val;
        w_illegal = 1'b0;
        case (opcode)
            c_OP_R: begin
                w_ctrl = f_arith(funct3, funct7_5, 1'b1);
            end
            c_OP_I: begin
                w_b    = imm;
                w_ctrl = f_arith(funct3, funct7_5, 1'b0);
            end
            c_OP_LOAD, c_OP_STORE: begin
                w_b = imm;
            end
            c_OP_BRANCH: begin
                case (funct3)
                    3'b000, 3'b001: w_ctrl = c_ALU_SUB;
                    3'b100, 3'b101: w_ctrl = c_ALU_SLT;
                    3'b110, 3'b111: w_ctrl = c_ALU_SLTU;
                    default: begin
                        w_ctrl    = c_ALU_ILL;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            c_OP_LUI: begin
                w_a = '0;
                w_b = imm;
            end
            c_OP_AUIPC: begin
                w_a = pc;
                w_b = imm;
            end
            c_OP_JAL, c_OP_JALR: begin
                // Link value pc + 4
                w_a = pc;
                w_b = XLEN'(4);
            end
            default: begin
                w_ctrl    = c_ALU_ILL;
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_payload = {w_illegal, w_ctrl, w_a, w_b};
    assign w_accept  = in_valid && in_ready;
    assign w_hs      = r_out_valid && out_ready;

`ifdef ALU_ISSUE_SKID_EN
    logic            r_skid_valid;
    logic [c_PW-1:0] r_skid;

    // Ready depends only on skid occupancy, never on out_ready
    assign in_ready = !rst && !r_skid_valid;

    // Output register plus skid entry; skid drains first to keep order
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out        <= c_RST_PAYLOAD;
            r_skid_valid <= 1'b0;
            r_skid       <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_out_valid || out_ready) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out       <= w_payload;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid       <= w_payload;
            r_skid_valid <= 1'b1;
        end
    end
`else
    // Accept whenever the output slot is empty or being drained this cycle
    assign in_ready = !rst && (!r_out_valid || out_ready);

    // Output register: load on accept, drop valid after an unreplaced handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out       <= c_RST_PAYLOAD;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out       <= w_payload;
            r_out_valid <= 1'b1;
        end else if (w_hs) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

    // Count completed output handshakes, including one coinciding with flush
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_hs) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign out_valid                             = r_out_valid;
    assign {illegal, alu_control, alu_a, alu_b} = r_out;
    assign issue_count                           = r_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_stage
// Description : Self-checking bench for alu_issue_stage. Expected payloads
//               are decoded by an independent model and queued on accept,
//               then compared against the DUT output while it is valid.
//               Honours ALU_ISSUE_SKID_EN for the in_ready model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    typedef struct packed {
        logic        ill;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_control;
    logic        illegal;
    logic [31:0] issue_count;

    int          n_assert;
    int          n_fail;
    int          m_count;
    int          saved_count;
    exp_t        sb[$];

    alu_issue_stage #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .rs1_val     (rs1_val),
        .rs2_val     (rs2_val),
        .imm         (imm),
        .pc          (pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .illegal     (illegal),
        .issue_count (issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decoder, written table-first
    function automatic exp_t m_decode(input logic [6:0] op, input logic [2:0] f3,
                                      input logic f75, input logic [31:0] r1,
                                      input logic [31:0] r2, input logic [31:0] im,
                                      input logic [31:0] p);
        logic [3:0] tab [8];
        exp_t e;
        tab    = '{4'h2, 4'h9, 4'h7, 4'hA, 4'h8, 4'hB, 4'h1, 4'h0};
        e.ill  = 1'b0;
        e.a    = r1;
        e.b    = r2;
        e.ctrl = 4'h2;
        if (op == 7'b0110011 || op == 7'b0010011) begin
            e.ctrl = tab[f3];
            if (f75 && f3 == 3'd5) e.ctrl = 4'hC;
            if (op == 7'b0110011 && f75 && f3 == 3'd0) e.ctrl = 4'h6;
            if (op == 7'b0010011) e.b = im;
        end else if (op == 7'b0000011 || op == 7'b0100011) begin
            e.b = im;
        end else if (op == 7'b1100011) begin
            if (f3[2:1] == 2'b00)      e.ctrl = 4'h6;
            else if (f3[2:1] == 2'b10) e.ctrl = 4'h7;
            else if (f3[2:1] == 2'b11) e.ctrl = 4'hA;
            else begin
                e.ctrl = 4'hF;
                e.ill  = 1'b1;
            end
        end else if (op == 7'b0110111) begin
            e.a = 32'd0;
            e.b = im;
        end else if (op == 7'b0010111) begin
            e.a = p;
            e.b = im;
        end else if (op == 7'b1101111 || op == 7'b1100111) begin
            e.a = p;
            e.b = 32'd4;
        end else begin
            e.ctrl = 4'hF;
            e.ill  = 1'b1;
        end
        return e;
    endfunction

    task automatic drv(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic f75, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] im, input logic [31:0] p);
        in_valid = v;
        opcode   = op;
        funct3   = f3;
        funct7_5 = f75;
        rs1_val  = r1;
        rs2_val  = r2;
        imm      = im;
        pc       = p;
    endtask

    task automatic idle();
        drv(1'b0, 7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    // Check the current cycle against the model, advance model, step one clock
    task automatic cycle();
        logic rdy;
        #1;
`ifdef ALU_ISSUE_SKID_EN
        rdy = !rst && (sb.size() < 2);
`else
        rdy = !rst && ((sb.size() == 0) || out_ready);
`endif
        chk("in_ready", in_ready, rdy);
        chk("out_valid", out_valid, sb.size() != 0);
        chk("issue_count", issue_count, m_count);
        if (sb.size() != 0)
            chk("payload", {illegal, alu_control, alu_a, alu_b}, sb[0]);
        if (rst) begin
            sb.delete();
            m_count = 0;
        end else begin
            if (sb.size() != 0 && out_ready) begin
                void'(sb.pop_front());
                m_count++;
            end
            if (flush) sb.delete();
            else if (in_valid && rdy)
                sb.push_back(m_decode(opcode, funct3, funct7_5, rs1_val, rs2_val, imm, pc));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, out_valid, 1'b0);
        chk({tag, "_illegal"}, illegal, 1'b0);
        chk({tag, "_a"}, alu_a, 32'd0);
        chk({tag, "_b"}, alu_b, 32'd0);
        chk({tag, "_ctrl"}, alu_control, 4'b0010);
        chk({tag, "_count"}, issue_count, 32'd0);
    endtask

    initial begin
        logic [6:0] ops [8];
        ops      = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                     7'b1100011, 7'b0110111, 7'b1101111, 7'b1100111};
        n_assert = 0;
        n_fail   = 0;
        m_count  = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;

        // R-type SUB
        out_ready = 1'b1;
        drv(1'b1, 7'b0110011, 3'd0, 1'b1, 32'd5, 32'd7, 32'd0, 32'd0);
        cycle();
        chk("sub_valid", out_valid, 1'b1);
        chk("sub_ctrl", alu_control, 4'b0110);
        chk("sub_a", alu_a, 32'd5);
        chk("sub_b", alu_b, 32'd7);
        chk("sub_illegal", illegal, 1'b0);

        // SRAI then AUIPC
        drv(1'b1, 7'b0010011, 3'd5, 1'b1, 32'h8000_0000, 32'd9, 32'd3, 32'd0);
        cycle();
        chk("srai_ctrl", alu_control, 4'b1100);
        chk("srai_b", alu_b, 32'd3);
        drv(1'b1, 7'b0010111, 3'd0, 1'b0, 32'd9, 32'd9, 32'h2000, 32'h100);
        cycle();
        chk("auipc_a", alu_a, 32'h100);
        chk("auipc_b", alu_b, 32'h2000);
        chk("auipc_ctrl", alu_control, 4'b0010);
        idle();
        cycle();
        chk("count_pre_stream", issue_count, 32'd3);

        // Back-to-back stream of 8
        for (int i = 0; i < 8; i++) begin
            drv(1'b1, ops[i], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, $urandom, $urandom);
            cycle();
        end
        idle();
        cycle();
        chk("stream_count", issue_count, 32'd11);

        // Stall for 3 cycles with in_valid held high
        drv(1'b1, 7'b0110011, 3'd0, 1'b0, 32'd11, 32'd22, 32'd0, 32'd0);
        cycle();
        out_ready = 1'b0;
        drv(1'b1, 7'b0110011, 3'd4, 1'b0, 32'd33, 32'd44, 32'd0, 32'd0);
        cycle();
        drv(1'b1, 7'b0110011, 3'd6, 1'b0, 32'd55, 32'd66, 32'd0, 32'd0);
        cycle();
        cycle();
        chk("stall_hold_a", alu_a, 32'd11);
        chk("stall_hold_b", alu_b, 32'd22);
        out_ready = 1'b1;
        idle();
        repeat (3) cycle();

        // Flush while stalled with a new instruction incoming
        drv(1'b1, 7'b0010011, 3'd7, 1'b0, 32'd77, 32'd0, 32'h0F, 32'd0);
        cycle();
        saved_count = m_count;
        out_ready = 1'b0;
        drv(1'b1, 7'b0010011, 3'd6, 1'b0, 32'd88, 32'd0, 32'hF0, 32'd0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        idle();
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_count", issue_count, saved_count);
        out_ready = 1'b1;
        repeat (2) cycle();

        // Illegal encodings
        drv(1'b1, 7'b1111111, 3'd0, 1'b0, 32'd3, 32'd4, 32'd5, 32'd6);
        cycle();
        chk("illop_flag", illegal, 1'b1);
        chk("illop_ctrl", alu_control, 4'b1111);
        chk("illop_a", alu_a, 32'd3);
        chk("illop_b", alu_b, 32'd4);
        drv(1'b1, 7'b1100011, 3'd2, 1'b0, 32'd1, 32'd2, 32'd0, 32'd0);
        cycle();
        chk("illbr_flag", illegal, 1'b1);
        chk("illbr_ctrl", alu_control, 4'b1111);
        idle();
        cycle();

        // Reset while stalled
        drv(1'b1, 7'b0110011, 3'd1, 1'b0, 32'h1234, 32'h5678, 32'd0, 32'd0);
        cycle();
        out_ready = 1'b0;
        idle();
        cycle();
        rst       = 1'b1;
        out_ready = 1'b1;
        cycle();
        rst = 1'b0;
        chk_reset("midstall_reset");
        repeat (2) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
